mpt2042_spi_frame_ctrl: RTL and testbench
=========================================

Name: mpt2042_spi_frame_ctrl

Overview:
- Frame-level sequencer directly upstream of the MPT2042 byte-wide SPI master.
- Accepts a multi-byte command frame from the register/command logic and owns chip select for the whole frame.
- Issues one byte at a time to the byte master over its req/ready/done handshake and collects the returned bytes into a read vector.
- Adds CS setup/hold/idle timing, inter-byte gaps, length checking and a per-byte timeout.

Parameters:
- MAX_BYTES, 4: maximum frame length in bytes, range 1..8.
- CS_SETUP_CLKCNT, 8'd4: clocks between CS falling and the first byte request.
- BYTE_GAP_CLKCNT, 8'd2: idle clocks between a byte's done and the next request.
- CS_HOLD_CLKCNT, 8'd4: clocks between the last done and CS rising.
- CS_IDLE_CLKCNT, 8'd8: minimum CS-high clocks before the next frame is accepted.
- TIMEOUT_CLKCNT, 16'd1024: maximum clocks to wait for i_spicom_done after a request.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_frame_req  in  1  single-cycle frame start; sampled only in IDLE
- i_frame_len  in  4  number of bytes in the frame; valid range 1..MAX_BYTES
- i_frame_wdata  in  8*MAX_BYTES  write bytes; byte 0 = [8*MAX_BYTES-1 -: 8], sent first
- o_frame_busy  out  1  high from acceptance through the end of CS_IDLE
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_err  out  1  valid with o_frame_done: 1 = bad length or timeout
- o_frame_rdata  out  8*MAX_BYTES  received bytes, same alignment as write data; held until the next frame is accepted
- o_spi_cs_n  out  1  chip select, active-low
- o_spicom_req  out  1  one-cycle byte request to the byte master
- o_spi_wdata  out  8  byte to send; valid in the o_spicom_req cycle
- i_spicom_ready  in  1  byte master idle
- i_spicom_done  in  1  byte master one-cycle completion pulse
- i_spi_rdbyte  in  8  byte received by the master; valid when i_spicom_done is high

Behaviour:
- Reset values (all registered): o_spi_cs_n=1, o_spicom_req=0, o_spi_wdata=0, o_frame_busy=0, o_frame_done=0, o_frame_err=0, o_frame_rdata=0. State=IDLE, all counters 0.
- States: IDLE, CHECK, CS_SETUP, BYTE_REQ, BYTE_WAIT, BYTE_GAP, CS_HOLD, CS_IDLE, DONE.
- IDLE:
  - On i_frame_req: latch length and write data, clear o_frame_rdata, set busy, go to CHECK.
  - i_frame_req while not in IDLE is ignored; no queueing.
- CHECK:
  - Length 0 or length > MAX_BYTES: go to DONE with err=1. CS never asserted, no byte request issued.
  - Otherwise: drive o_spi_cs_n=0, byte index=0, go to CS_SETUP.
- CS_SETUP: count CS_SETUP_CLKCNT clocks, then go to BYTE_REQ.
- BYTE_REQ:
  - Wait for i_spicom_ready=1.
  - Then pulse o_spicom_req for exactly 1 cycle with o_spi_wdata = the current byte.
  - Clear the timeout counter and go to BYTE_WAIT.
- BYTE_WAIT:
  - On i_spicom_done: store i_spi_rdbyte at the current index and increment the index.
    - If the index now equals the length, go to CS_HOLD.
    - Otherwise go to BYTE_GAP.
  - If the timeout counter reaches TIMEOUT_CLKCNT-1 without done: set the error flag and go to CS_HOLD (abort).
  - If done and timeout occur in the same cycle, done wins.
- BYTE_GAP: count BYTE_GAP_CLKCNT clocks (0 = go straight through), then go to BYTE_REQ.
- CS_HOLD: count CS_HOLD_CLKCNT clocks, then drive o_spi_cs_n=1 and go to CS_IDLE.
- CS_IDLE: count CS_IDLE_CLKCNT clocks, then go to DONE.
- DONE:
  - o_frame_done=1 for one cycle, with o_frame_err set to the error flag.
  - busy drops in the same cycle; return to IDLE.
- Gap, hold and idle counters are 8-bit. A programmed count of 0 means a single pass-through cycle.
- Latency, frame of N bytes with no errors: first o_spicom_req occurs 2+CS_SETUP_CLKCNT+1 clocks after the i_frame_req cycle. CS is low continuously across all N bytes.
- Byte master done/ready rules:
  - i_spicom_done is only honoured in BYTE_WAIT; a stray done in any other state is ignored.
  - No new request is made until ready is seen high after done.
- Reset mid-frame: on the next edge CS goes high and req goes low. No done pulse is issued for the aborted frame.

Optional Feature:
- Macro: MPT2042_FRAME_CRC_EN.
- Defined:
  - After the last data byte, one extra byte is sent: CRC-8 over the N write bytes (poly 0x07, init 0x00, MSB-first), inside the same CS window.
  - The byte received during the CRC byte is discarded and not stored in o_frame_rdata.
  - Length checking still applies to N only.
- Undefined: the frame is exactly N bytes and no CRC logic is synthesised.

Test Plan:
- Frame of 3 bytes, wdata=32'hA5_3C_0F_xx, master model echoes ~wdata -> exactly 3 requests carrying A5, 3C, 0F; CS low throughout; rdata=32'h5A_C3_F0_00; done=1, err=0.
- Length 0, then length 5 with MAX_BYTES=4 -> done 2 cycles after req with err=1; CS stays high; no o_spicom_req.
- Master model never returns done -> abort after exactly 1024 wait clocks; CS rises CS_HOLD_CLKCNT later; err=1.
- i_frame_req re-asserted while busy, and a stray i_spicom_done in BYTE_GAP -> both ignored; a single frame completes.
- i_rst asserted during the second byte of a 4-byte frame -> next edge: cs_n=1, busy=0, rdata=0; a following frame completes normally.
- With MPT2042_FRAME_CRC_EN defined, frame 2 bytes 8'h01, 8'h02 -> third byte sent is 8'h1B; rdata holds only 2 bytes.

Source files
------------

// File: rtl/mpt2042_spi_frame_ctrl.sv
// Frame sequencer in front of the MPT2042 byte-wide SPI master: owns CS, paces bytes, gathers read data.
// Define MPT2042_FRAME_CRC_EN to append a CRC-8 (poly 0x07) byte after the data bytes.
module mpt2042_spi_frame_ctrl #(
    parameter int          MAX_BYTES       = 4,
    parameter logic [7:0]  CS_SETUP_CLKCNT = 8'd4,
    parameter logic [7:0]  BYTE_GAP_CLKCNT = 8'd2,
    parameter logic [7:0]  CS_HOLD_CLKCNT  = 8'd4,
    parameter logic [7:0]  CS_IDLE_CLKCNT  = 8'd8,
    parameter logic [15:0] TIMEOUT_CLKCNT  = 16'd1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_req,
    input  logic [3:0]             i_frame_len,
    input  logic [8*MAX_BYTES-1:0] i_frame_wdata,
    output logic                   o_frame_busy,
    output logic                   o_frame_done,
    output logic                   o_frame_err,
    output logic [8*MAX_BYTES-1:0] o_frame_rdata,
    output logic                   o_spi_cs_n,
    output logic                   o_spicom_req,
    output logic [7:0]             o_spi_wdata,
    input  logic                   i_spicom_ready,
    input  logic                   i_spicom_done,
    input  logic [7:0]             i_spi_rdbyte
);
    // Byte handshake: a request is raised only after i_spicom_ready was seen high; o_spicom_req is a
    // one-cycle pulse with o_spi_wdata valid in that cycle; i_spicom_done/i_spi_rdbyte count only in BYTE_WAIT.
    typedef enum logic [3:0] {
        IDLE, CHECK, CS_SETUP, BYTE_REQ, BYTE_WAIT, BYTE_GAP, CS_HOLD, CS_IDLE, DONE
    } state_t;

    state_t                 state_q;
    logic [7:0]             cnt_q;
    logic [15:0]            to_cnt_q;
    logic [3:0]             len_q;
    logic [3:0]             idx_q;
    logic [3:0]             idx_nxt;
    logic [8*MAX_BYTES-1:0] wbuf_q;
    logic                   err_q;
`ifdef MPT2042_FRAME_CRC_EN
    logic [7:0]             crc_q;
    logic                   crc_phase_q;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    assign idx_nxt = idx_q + 4'd1;

    // A programmed count of 0 still spends one cycle in the state.
    function automatic logic cnt_last(input logic [7:0] cnt, input logic [7:0] limit);
        return ({1'b0, cnt} + 9'd1) >= {1'b0, limit};
    endfunction

    function automatic logic [8*MAX_BYTES-1:0] put_byte(input logic [8*MAX_BYTES-1:0] vec,
                                                        input logic [3:0] idx, input logic [7:0] din);
        logic [8*MAX_BYTES-1:0] v;
        v = vec;
        for (int b = 0; b < MAX_BYTES; b++)
            if (idx == 4'(b)) v[8*(MAX_BYTES-1-b) +: 8] = din;
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            to_cnt_q      <= 16'd0;
            len_q         <= 4'd0;
            idx_q         <= 4'd0;
            wbuf_q        <= '0;
            err_q         <= 1'b0;
            o_frame_busy  <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_frame_rdata <= '0;
            o_spi_cs_n    <= 1'b1;
            o_spicom_req  <= 1'b0;
            o_spi_wdata   <= 8'd0;
`ifdef MPT2042_FRAME_CRC_EN
            crc_q         <= 8'd0;
            crc_phase_q   <= 1'b0;
`endif
        end else begin
            o_spicom_req <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            case (state_q)
                IDLE: if (i_frame_req) begin
                    len_q         <= i_frame_len;
                    wbuf_q        <= i_frame_wdata;
                    o_frame_rdata <= '0;
                    o_frame_busy  <= 1'b1;
                    err_q         <= 1'b0;
                    state_q       <= CHECK;
                end
                CHECK: begin
                    if (len_q == 4'd0 || int'(len_q) > MAX_BYTES) begin
                        o_frame_done <= 1'b1;
                        o_frame_err  <= 1'b1;
                        o_frame_busy <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        o_spi_cs_n <= 1'b0;
                        idx_q      <= 4'd0;
                        cnt_q      <= 8'd0;
`ifdef MPT2042_FRAME_CRC_EN
                        crc_q       <= 8'd0;
                        crc_phase_q <= 1'b0;
`endif
                        state_q    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt_last(cnt_q, CS_SETUP_CLKCNT)) begin
                        cnt_q   <= 8'd0;
                        state_q <= BYTE_REQ;
                    end else cnt_q <= cnt_q + 8'd1;
                end
                BYTE_REQ: if (i_spicom_ready) begin
                    o_spicom_req <= 1'b1;
                    to_cnt_q     <= 16'd0;
                    state_q      <= BYTE_WAIT;
`ifdef MPT2042_FRAME_CRC_EN
                    if (crc_phase_q) o_spi_wdata <= crc_q;
                    else begin
                        o_spi_wdata <= wbuf_q[8*MAX_BYTES-1 -: 8];
                        crc_q       <= crc8_step(crc_q, wbuf_q[8*MAX_BYTES-1 -: 8]);
                        wbuf_q      <= wbuf_q << 8;
                    end
`else
                    o_spi_wdata <= wbuf_q[8*MAX_BYTES-1 -: 8];
                    wbuf_q      <= wbuf_q << 8;
`endif
                end
                BYTE_WAIT: begin
                    // Done beats timeout when both land in the same cycle.
                    if (i_spicom_done) begin
                        cnt_q <= 8'd0;
`ifdef MPT2042_FRAME_CRC_EN
                        if (crc_phase_q) state_q <= CS_HOLD;
                        else begin
                            o_frame_rdata <= put_byte(o_frame_rdata, idx_q, i_spi_rdbyte);
                            idx_q         <= idx_nxt;
                            if (idx_nxt == len_q) crc_phase_q <= 1'b1;
                            state_q       <= BYTE_GAP;
                        end
`else
                        o_frame_rdata <= put_byte(o_frame_rdata, idx_q, i_spi_rdbyte);
                        idx_q         <= idx_nxt;
                        state_q       <= (idx_nxt == len_q) ? CS_HOLD : BYTE_GAP;
`endif
                    end else if (to_cnt_q == TIMEOUT_CLKCNT - 16'd1) begin
                        err_q   <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= CS_HOLD;
                    end else to_cnt_q <= to_cnt_q + 16'd1;
                end
                BYTE_GAP: begin
                    if (cnt_last(cnt_q, BYTE_GAP_CLKCNT)) begin
                        cnt_q   <= 8'd0;
                        state_q <= BYTE_REQ;
                    end else cnt_q <= cnt_q + 8'd1;
                end
                CS_HOLD: begin
                    if (cnt_last(cnt_q, CS_HOLD_CLKCNT)) begin
                        o_spi_cs_n <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= CS_IDLE;
                    end else cnt_q <= cnt_q + 8'd1;
                end
                CS_IDLE: begin
                    if (cnt_last(cnt_q, CS_IDLE_CLKCNT)) begin
                        cnt_q        <= 8'd0;
                        o_frame_done <= 1'b1;
                        o_frame_err  <= err_q;
                        o_frame_busy <= 1'b0;
                        state_q      <= DONE;
                    end else cnt_q <= cnt_q + 8'd1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpt2042_spi_frame_ctrl.sv
// Directed bench for mpt2042_spi_frame_ctrl with a simple byte-master model and request monitor.
module tb_mpt2042_spi_frame_ctrl;
    localparam int MAXB = 4;
    localparam int W    = 8 * MAXB;

    logic         clk = 1'b0;
    logic         rst;
    logic         frame_req;
    logic [3:0]   frame_len;
    logic [W-1:0] frame_wdata;
    logic         busy, fdone, ferr;
    logic [W-1:0] rdata;
    logic         cs_n, spicom_req;
    logic [7:0]   spi_wdata;
    logic         spicom_ready, spicom_done;
    logic [7:0]   spi_rdbyte;

    always #5 clk = ~clk;

    mpt2042_spi_frame_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_frame_req(frame_req), .i_frame_len(frame_len),
        .i_frame_wdata(frame_wdata), .o_frame_busy(busy), .o_frame_done(fdone),
        .o_frame_err(ferr), .o_frame_rdata(rdata), .o_spi_cs_n(cs_n),
        .o_spicom_req(spicom_req), .o_spi_wdata(spi_wdata), .i_spicom_ready(spicom_ready),
        .i_spicom_done(spicom_done), .i_spi_rdbyte(spi_rdbyte)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] req_q[$];
    int         req_cyc_q[$];
    logic [7:0] exp_q[$];
    int   req_cs_hi = 0, cs_rise = 0, cs_fall = 0, cs_rise_cyc = 0, done_cnt = 0;
    logic prev_cs = 1'b1;
    int   master_mode = 0;
    bit   stray_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (spicom_req === 1'b1) begin
            req_q.push_back(spi_wdata);
            req_cyc_q.push_back(cyc);
            if (cs_n !== 1'b0) req_cs_hi <= req_cs_hi + 1;
        end
        if (fdone === 1'b1) done_cnt <= done_cnt + 1;
        if (!prev_cs && cs_n) begin
            cs_rise     <= cs_rise + 1;
            cs_rise_cyc <= cyc;
        end
        if (prev_cs && !cs_n) cs_fall <= cs_fall + 1;
        prev_cs <= cs_n;
    end

    // Byte master: done 3 cycles after a request, echoing the inverted byte.
    initial begin : master
        int busy_cnt;
        bit stray_pending;
        logic [7:0] held;
        busy_cnt = 0; stray_pending = 0; held = 8'h00;
        spicom_ready = 1'b1; spicom_done = 1'b0; spi_rdbyte = 8'h00;
        forever begin
            @(posedge clk); #1;
            spicom_done = 1'b0;
            if (stray_pending) begin
                spicom_done = 1'b1; spi_rdbyte = 8'h77; stray_pending = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    spicom_done = 1'b1; spi_rdbyte = ~held; spicom_ready = 1'b1;
                    if (stray_mode) stray_pending = 1;
                end
            end else if (spicom_req === 1'b1 && master_mode == 0) begin
                held = spi_wdata; spicom_ready = 1'b0; busy_cnt = 3;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [3:0] len, input logic [W-1:0] wd, input int poke_at,
                             output int lat, output int start_cyc);
        frame_len = len; frame_wdata = wd; frame_req = 1'b1; start_cyc = cyc;
        tick(); lat = 1; frame_req = 1'b0;
        while (fdone !== 1'b1 && lat < 2000) begin
            frame_req = (lat == poke_at);
            tick(); lat++;
        end
        frame_req = 1'b0;
        chk("frame_done_seen", fdone, 1);
    endtask

    initial begin : main
        int lat, s0, base_req, base_rise, base_fall, base_done;
        rst = 1'b1; frame_req = 1'b0; frame_len = 4'd0; frame_wdata = '0;
        repeat (3) tick();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_req", spicom_req, 0);
        chk("rst_wdata", spi_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fdone, 0);
        chk("rst_err", ferr, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0; tick();

        // Three-byte frame with echoing master
        base_req = req_q.size(); base_rise = cs_rise; base_fall = cs_fall;
        run_frame(4'd3, 32'hA5_3C_0F_00, -1, lat, s0);
        chk("t1_latency", lat, 37);
        chk("t1_err", ferr, 0);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_rdata", rdata, 32'h5A_C3_F0_00);
        chk("t1_req_count", req_q.size() - base_req, 3);
        chk("t1_first_req_lat", req_cyc_q[base_req] - s0, 7);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'h0F);
        for (int i = 0; i < 3; i++) chk("t1_req_byte", req_q[base_req + i], exp_q.pop_front());
        chk("t1_cs_fall", cs_fall - base_fall, 1);
        chk("t1_cs_rise", cs_rise - base_rise, 1);
        chk("t1_req_cs_hi", req_cs_hi, 0);
        tick();

        // Bad lengths 0 and 5
        base_req = req_q.size(); base_fall = cs_fall;
        run_frame(4'd0, 32'hFFFF_FFFF, -1, lat, s0);
        chk("t2_len0_latency", lat, 2);
        chk("t2_len0_err", ferr, 1);
        chk("t2_len0_rdata_cleared", rdata, 0);
        tick();
        run_frame(4'd5, 32'h1234_5678, -1, lat, s0);
        chk("t2_len5_latency", lat, 2);
        chk("t2_len5_err", ferr, 1);
        chk("t2_len5_busy", busy, 0);
        chk("t2_req_count", req_q.size() - base_req, 0);
        chk("t2_cs_fall", cs_fall - base_fall, 0);
        tick();

        // Timeout: master never completes
        master_mode = 1;
        base_req = req_q.size();
        run_frame(4'd1, 32'h3C00_0000, -1, lat, s0);
        chk("t3_latency", lat, 1043);
        chk("t3_err", ferr, 1);
        chk("t3_rdata", rdata, 0);
        chk("t3_req_count", req_q.size() - base_req, 1);
        chk("t3_cs_rise_after_req", cs_rise_cyc - req_cyc_q[base_req], 1028);
        master_mode = 0;
        tick();

        // Frame request while busy and stray done in gap/hold
        stray_mode = 1'b1;
        base_req = req_q.size();
        run_frame(4'd2, 32'h11_22_00_00, 12, lat, s0);
        stray_mode = 1'b0;
        chk("t4_latency", lat, 30);
        chk("t4_err", ferr, 0);
        chk("t4_rdata", rdata, 32'hEE_DD_00_00);
        chk("t4_req_byte0", req_q[base_req], 8'h11);
        chk("t4_req_byte1", req_q[base_req + 1], 8'h22);
        repeat (10) tick();
        chk("t4_no_queued_busy", busy, 0);
        chk("t4_req_count", req_q.size() - base_req, 2);

        // Reset during the second byte of a four-byte frame
        base_req = req_q.size();
        frame_len = 4'd4; frame_wdata = 32'h01_02_03_04; frame_req = 1'b1;
        tick(); frame_req = 1'b0;
        repeat (14) tick();
        chk("t5_rdata_before_rst", rdata, 32'hFE_00_00_00);
        chk("t5_cs_low_before_rst", cs_n, 0);
        chk("t5_req_count_before_rst", req_q.size() - base_req, 2);
        rst = 1'b1; tick();
        chk("t5_rst_cs_n", cs_n, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rdata", rdata, 0);
        chk("t5_rst_req", spicom_req, 0);
        rst = 1'b0; base_done = done_cnt;
        repeat (20) tick();
        chk("t5_no_done_after_abort", done_cnt - base_done, 0);
        run_frame(4'd1, 32'h5A00_0000, -1, lat, s0);
        chk("t5_next_latency", lat, 23);
        chk("t5_next_err", ferr, 0);
        chk("t5_next_rdata", rdata, 32'hA5_00_00_00);
        tick();

`ifdef MPT2042_FRAME_CRC_EN
        // Two data bytes plus trailing CRC-8 (0x01,0x02 -> 0x1B)
        base_req = req_q.size();
        run_frame(4'd2, 32'h01_02_00_00, -1, lat, s0);
        chk("t6_latency", lat, 37);
        chk("t6_req_count", req_q.size() - base_req, 3);
        chk("t6_crc_byte", req_q[base_req + 2], 8'h1B);
        chk("t6_rdata", rdata, 32'hFE_FD_00_00);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
